dram_arbiter: RTL and testbench

Two-master arbiter for the single DRAM port. The port sits behind the bus bridge: the CPU data path (master 0) and a secondary word-access requester (master 1, e.g. a program loader or debug block) share it. The CPU keeps absolute priority so the single-cycle core is never delayed in normal operation. Master 1 is served in CPU-idle cycles through a req/gnt/rvalid handshake, with an optional starvation guard that briefly stalls the CPU.

---
 rtl/dram_arbiter_pkg.sv | 13 +
 rtl/dram_arbiter_starve_cnt.sv | 36 +++
 rtl/dram_arbiter.sv | 107 ++++++++++
 tb/tb_dram_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the two-master DRAM arbiter: FSM encodings and default limits.
// The starvation guard is enabled by defining ARB_STARVE_GUARD_EN at compile time.
package dram_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_RESP = 1'b1
   } arb_state_e;

   localparam int DEF_STARVE_LIMIT = 8;
   localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/dram_arbiter_starve_cnt.sv
// Saturating count of consecutive denied master-1 cycles; only built when
// ARB_STARVE_GUARD_EN is defined. Clear wins over increment; en_i low holds the count.
module arb_starve_cnt #(
   parameter int CNT_W = 4,
   parameter int LIMIT = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if (clr_i)
            cnt_d = '0;
         else if (inc_i && !at_limit_o)
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dram_arbiter.sv
// DRAM port arbiter: CPU has absolute priority, master 1 is served in CPU-idle cycles.
// Defining ARB_STARVE_GUARD_EN adds a forced grant that stalls the CPU for one cycle.
module dram_arbiter
   import dram_arbiter_pkg::*;
#(
   parameter int AW           = 14,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [31:0]   cpu_addr,
   input  logic [31:0]   cpu_wdata,
   output logic [31:0]   cpu_rdata,
   output logic          cpu_stall,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [31:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic [AW-1:0] dram_a,
   output logic          dram_we,
   output logic [31:0]   dram_d,
   input  logic [31:0]   dram_spo,
   output logic          dbg_state_o
);

   arb_state_e  state_q, state_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;
   logic        idle;
   logic        forced;
   logic        gnt;
   logic        unused_ok;

   assign idle = (state_q == ARB_IDLE);

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_cnt #(
      .CNT_W (CNT_W),
      .LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk_i      (cpu_clk),
      .rst_i      (cpu_rst),
      .en_i       (idle),
      .inc_i      (m1_req && cpu_req && !gnt),
      .clr_i      (gnt || !m1_req),
      .at_limit_o (forced)
   );
   // A grant while the CPU is requesting can only be a forced one.
   assign cpu_stall = gnt && cpu_req;
   assign unused_ok = ^{m1_addr[31:AW+2], m1_addr[1:0], cpu_addr[31:AW+2], cpu_addr[1:0]};
`else
   assign forced    = 1'b0;
   assign cpu_stall = 1'b0;
   assign unused_ok = ^{m1_addr[31:AW+2], m1_addr[1:0], cpu_addr[31:AW+2], cpu_addr[1:0],
                        STARVE_LIMIT[0], CNT_W[0]};
`endif

   assign gnt         = !cpu_rst && idle && m1_req && (!cpu_req || forced);
   assign m1_gnt      = gnt;
   assign m1_rvalid   = (state_q == ARB_RESP);
   assign m1_rdata    = m1_rdata_q;
   assign cpu_rdata   = dram_spo;
   assign dbg_state_o = state_q;

   always_comb begin
      dram_a  = cpu_addr[AW+1:2];
      dram_d  = cpu_wdata;
      dram_we = !cpu_rst && cpu_req && cpu_we;
      if (gnt) begin
         dram_a  = m1_addr[AW+1:2];
         dram_d  = m1_wdata;
         dram_we = m1_we;
      end
   end

   // Reads park in RESP for one cycle; writes commit on the grant edge and stay in IDLE.
   always_comb begin
      state_d    = state_q;
      m1_rdata_d = m1_rdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (gnt && !m1_we) begin
               state_d    = ARB_RESP;
               m1_rdata_d = dram_spo;
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q    <= ARB_IDLE;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter with a behavioural DRAM; master-1 read data is checked by a
// monitor against an expected queue. Honours ARB_STARVE_GUARD_EN for guard expectations.
module tb_dram_arbiter;

   localparam int AW = 14;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          cpu_clk, cpu_rst;
   logic          cpu_req, cpu_we;
   logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          m1_req, m1_we;
   logic [31:0]   m1_addr, m1_wdata;
   logic          m1_gnt, m1_rvalid;
   logic [31:0]   m1_rdata;
   logic [AW-1:0] dram_a;
   logic          dram_we;
   logic [31:0]   dram_d, dram_spo;
   logic          dbg_state;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic [31:0]   exp_q[$];
   int            checks = 0;
   int            errors = 0;
   bit            granted;

   dram_arbiter #(.AW(AW), .STARVE_LIMIT(8), .CNT_W(4)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .m1_req      (m1_req),
      .m1_we       (m1_we),
      .m1_addr     (m1_addr),
      .m1_wdata    (m1_wdata),
      .m1_gnt      (m1_gnt),
      .m1_rvalid   (m1_rvalid),
      .m1_rdata    (m1_rdata),
      .dram_a      (dram_a),
      .dram_we     (dram_we),
      .dram_d      (dram_d),
      .dram_spo    (dram_spo),
      .dbg_state_o (dbg_state)
   );

   // clock and DRAM model
   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   assign dram_spo = mem[dram_a];
   always @(posedge cpu_clk) if (dram_we) mem[dram_a] <= dram_d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: new inputs after the falling edge, outputs sampled 1 time unit later
   task automatic step(input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                       input logic mr, input logic mwe, input logic [31:0] ma, input logic [31:0] mwd);
      @(negedge cpu_clk);
      cpu_req = cr;  cpu_we = cwe;  cpu_addr = ca;  cpu_wdata = cwd;
      m1_req  = mr;  m1_we  = mwe;  m1_addr  = ma;  m1_wdata  = mwd;
      #1;
   endtask

   // monitor: every rvalid pulse must match the oldest expected read
   always @(negedge cpu_clk) begin
      if (m1_rvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rdata %h expected no response at %0t", m1_rdata, $time);
         end else begin
            chk("m1_rdata", m1_rdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[16] = 32'hDEADBEEF;
      cpu_rst = 1'b1;
      granted = 1'b0;

      // reset holds everything quiet, even with both masters requesting
      step(0, 0, 0, 0, 1, 0, 32'h40, 0);
      step(1, 1, 32'h200, 32'h77, 1, 0, 32'h40, 0);
      chk("rst_gnt", m1_gnt, 0);
      chk("rst_dram_we", dram_we, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rvalid", m1_rvalid, 0);
      chk("rst_rdata", m1_rdata, 0);
      chk("rst_state", dbg_state, 0);

      // first cycle after release: CPU-idle read of 0x40
      @(negedge cpu_clk);
      cpu_rst = 1'b0;  cpu_req = 1'b0;  cpu_we = 1'b0;
      #1;
      chk("first_gnt", m1_gnt, 1);
      chk("read_dram_a", dram_a, 32'h10);
      chk("read_dram_we", dram_we, 0);
      exp_q.push_back(32'hDEADBEEF);

      // RESP cycle: new request must wait
      step(0, 0, 0, 0, 1, 0, 32'h40, 0);
      chk("resp_no_gnt", m1_gnt, 0);
      chk("resp_rvalid", m1_rvalid, 1);
      chk("resp_state", dbg_state, 1);
      step(0, 0, 0, 0, 1, 0, 32'h40, 0);
      chk("regnt_after_resp", m1_gnt, 1);
      exp_q.push_back(32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // back-to-back master-1 writes, then CPU reads one back
      step(0, 0, 0, 0, 1, 1, 32'h44, 32'h12345678);
      chk("wr_gnt", m1_gnt, 1);
      chk("wr_dram_we", dram_we, 1);
      chk("wr_dram_a", dram_a, 32'h11);
      chk("wr_dram_d", dram_d, 32'h12345678);
      step(0, 0, 0, 0, 1, 1, 32'h48, 32'hCAFEF00D);
      chk("wr2_gnt", m1_gnt, 1);
      chk("wr2_dram_a", dram_a, 32'h12);
      step(1, 0, 32'h44, 0, 0, 0, 0, 0);
      chk("cpu_rd_44", cpu_rdata, 32'h12345678);
      chk("cpu_rd_we", dram_we, 0);

      // CPU priority: five busy cycles of CPU writes, grant in the sixth
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i), 1, 0, 32'h48, 0);
         chk("prio_no_gnt", m1_gnt, 0);
         chk("prio_cpu_we", dram_we, 1);
         chk("prio_dram_a", dram_a, 32'h20 + 32'(i));
         chk("prio_stall", cpu_stall, 0);
      end
      step(0, 0, 0, 0, 1, 0, 32'h48, 0);
      chk("prio_gnt", m1_gnt, 1);
      exp_q.push_back(32'hCAFEF00D);
      step(1, 0, 32'h84, 0, 0, 0, 0, 0);
      chk("prio_resp_cpu_rd", cpu_rdata, 32'hA1);
      step(1, 0, 32'h90, 0, 0, 0, 0, 0);
      chk("prio_cpu_rd_90", cpu_rdata, 32'hA4);

      // starvation: CPU writes every cycle while master 1 holds a read request
      for (int i = 1; i <= 12; i++) begin
         step(1, 1, 32'h100, 32'(i), !granted, 0, 32'h40, 0);
         chk("starve_gnt", m1_gnt, GUARD && (i == 9));
         chk("starve_stall", cpu_stall, GUARD && (i == 9));
         chk("starve_dram_we", dram_we, !(GUARD && (i == 9)));
         if (m1_gnt) begin
            granted = 1'b1;
            exp_q.push_back(32'hDEADBEEF);
         end
      end
      step(0, 0, 0, 0, !GUARD, 0, 32'h40, 0);
      chk("gnt_after_cpu_idle", m1_gnt, !GUARD);
      if (m1_gnt) exp_q.push_back(32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // reset asserted in the RESP cycle of a read
      step(0, 0, 0, 0, 1, 0, 32'h44, 0);
      chk("rr_gnt", m1_gnt, 1);
      exp_q.push_back(32'h12345678);
      @(negedge cpu_clk);
      m1_req = 1'b0;
      #2;
      cpu_rst = 1'b1;
      #1;
      chk("rr_rvalid_drop", m1_rvalid, 0);
      chk("rr_state_idle", dbg_state, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0);
         chk("rr_no_rvalid", m1_rvalid, 0);
      end

      chk("exp_q_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
